// File: rtl/activation_memory_arbiter.sv
// ---------------------------------------------------------------------------
// activation_memory_arbiter
//
// Shares the single port of the activation memory (synchronous SRAM, one
// cycle read latency) between the compute control path (ctrl) and the SPI
// programming/readback path (spi).
//
// Features:
//   - valid/ready request handshakes, one grant per cycle, ctrl priority
//   - spi starvation bound: a waiting spi request loses at most STARVE_LIMIT
//     consecutive arbitrations before it is forced through
//   - tagged read return: the response goes back to whoever issued the read
//   - power-down sequencing: auto-sleep after IDLE_CYCLES idle cycles, forced
//     sleep on global_power_down, and a one-cycle WAKE state on exit
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ctrl_req_* / spi_req_*       request: valid, write, address, data, mask
//   ctrl_req_ready/spi_req_ready request accepted this cycle (combinational)
//   ctrl_rsp_valid/spi_rsp_valid one-cycle read response strobe
//   ctrl_rsp_data                read data, straight from the memory
//   spi_rsp_data                 read data, registered and held
//   global_power_down            force the memory into power-down
//   mem_*                        memory wrapper interface
// ---------------------------------------------------------------------------
module activation_memory_arbiter #(
    parameter int  WIDTH        = 64,
    parameter int  NUM_ROWS     = 32,
    parameter int  STARVE_LIMIT = 4,
    parameter int  IDLE_CYCLES  = 16,
    localparam int ADDR_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic              clk,
    input  logic              rst,

    // ctrl requester
    input  logic              ctrl_req_valid,
    input  logic              ctrl_req_write,
    input  logic [ADDR_W-1:0] ctrl_req_address,
    input  logic [WIDTH-1:0]  ctrl_req_data,
    input  logic [WIDTH-1:0]  ctrl_req_mask,
    output logic              ctrl_req_ready,
    output logic              ctrl_rsp_valid,
    output logic [WIDTH-1:0]  ctrl_rsp_data,

    // spi requester
    input  logic              spi_req_valid,
    input  logic              spi_req_write,
    input  logic [ADDR_W-1:0] spi_req_address,
    input  logic [WIDTH-1:0]  spi_req_data,
    input  logic [WIDTH-1:0]  spi_req_mask,
    output logic              spi_req_ready,
    output logic              spi_rsp_valid,
    output logic [WIDTH-1:0]  spi_rsp_data,

    // power control
    input  logic              global_power_down,

    // memory wrapper
    output logic              mem_read_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_address_read,
    output logic [ADDR_W-1:0] mem_address_write,
    output logic [WIDTH-1:0]  mem_data_in,
    output logic [WIDTH-1:0]  mem_mask,
    output logic              mem_power_down,
    input  logic [WIDTH-1:0]  mem_data_out
);

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    localparam int             STARVE_W   = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // idle_count only needs to reach IDLE_CYCLES-1: the transition to SLEEP
    // happens on the edge where the count would reach IDLE_CYCLES.
    localparam bit             IDLE_EN    = (IDLE_CYCLES > 0);
    localparam int             IDLE_W     = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_EN ? IDLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_WAKE   = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state;
    logic [STARVE_W-1:0] starve_count;
    logic [IDLE_W-1:0]   idle_count;

    logic ctrl_grant;
    logic spi_grant;
    logic idle_now;

    // -----------------------------------------------------------------------
    // Arbitration
    //
    // Grants are only issued in ACTIVE. While global_power_down is high no
    // request is accepted, so no read can be launched that would return
    // after the memory has been powered down; the read already in flight
    // returns in this cycle while mem_power_down is still low.
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default at the top of
    // the block so that no path leaves it unassigned and a latch is inferred.
    always_comb begin
        ctrl_grant = 1'b0;
        spi_grant  = 1'b0;
        if (state == ST_ACTIVE && !global_power_down) begin
            if (spi_req_valid && (starve_count == STARVE_MAX || !ctrl_req_valid)) begin
                spi_grant = 1'b1;
            end else if (ctrl_req_valid) begin
                ctrl_grant = 1'b1;
            end
        end
    end

    assign ctrl_req_ready = ctrl_grant;
    assign spi_req_ready  = spi_grant;

    // -----------------------------------------------------------------------
    // Memory drive: the granted request goes straight to the memory port;
    // with no grant everything is held at zero.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_read_enable   = 1'b0;
        mem_write_enable  = 1'b0;
        mem_address_read  = '0;
        mem_address_write = '0;
        mem_data_in       = '0;
        mem_mask          = '0;
        if (spi_grant) begin
            mem_read_enable   = !spi_req_write;
            mem_write_enable  = spi_req_write;
            mem_address_read  = spi_req_address;
            mem_address_write = spi_req_address;
            mem_data_in       = spi_req_data;
            mem_mask          = spi_req_mask;
        end else if (ctrl_grant) begin
            mem_read_enable   = !ctrl_req_write;
            mem_write_enable  = ctrl_req_write;
            mem_address_read  = ctrl_req_address;
            mem_address_write = ctrl_req_address;
            mem_data_in       = ctrl_req_data;
            mem_mask          = ctrl_req_mask;
        end
    end

    // ctrl sees the memory output directly; it is only meaningful while
    // ctrl_rsp_valid is high.
    assign ctrl_rsp_data = mem_data_out;

    // A cycle counts as idle when nothing is requested and no read data is
    // being returned.
    assign idle_now = (state == ST_ACTIVE) && !ctrl_req_valid && !spi_req_valid
                      && !ctrl_rsp_valid && !spi_rsp_valid;

    // -----------------------------------------------------------------------
    // Sequential state: read tag, spi read data, starvation and idle
    // counters, power state machine.
    //
    // ctrl_rsp_valid / spi_rsp_valid double as the read tag: exactly one of
    // them is set on the edge after a read grant, naming the owner of the
    // data the memory presents in the following cycle.
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // that every flop samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_ACTIVE;
            starve_count   <= '0;
            idle_count     <= '0;
            ctrl_rsp_valid <= 1'b0;
            spi_rsp_valid  <= 1'b0;
            spi_rsp_data   <= '0;
            mem_power_down <= 1'b0;
        end else begin
            // Read tag
            ctrl_rsp_valid <= ctrl_grant && !ctrl_req_write;
            spi_rsp_valid  <= spi_grant && !spi_req_write;

            // spi read data is captured in the return cycle and held until
            // the next spi read returns.
            if (spi_rsp_valid) begin
                spi_rsp_data <= mem_data_out;
            end

            // Starvation counter: counts arbitrations lost by a waiting spi
            // request, including cycles spent outside ACTIVE.
            if (!spi_req_valid || spi_grant) begin
                starve_count <= '0;
            end else if (starve_count != STARVE_MAX) begin
                starve_count <= starve_count + 1'b1;
            end

            // Power state machine
            unique case (state)
                ST_ACTIVE: begin
                    if (global_power_down) begin
                        state          <= ST_SLEEP;
                        mem_power_down <= 1'b1;
                        idle_count     <= '0;
                    end else if (idle_now) begin
                        if (IDLE_EN && idle_count == IDLE_LAST) begin
                            state          <= ST_SLEEP;
                            mem_power_down <= 1'b1;
                            idle_count     <= '0;
                        end else if (idle_count != IDLE_LAST) begin
                            idle_count <= idle_count + 1'b1;
                        end
                    end else begin
                        idle_count <= '0;
                    end
                end

                ST_SLEEP: begin
                    idle_count <= '0;
                    if (!global_power_down && (ctrl_req_valid || spi_req_valid)) begin
                        state          <= ST_WAKE;
                        mem_power_down <= 1'b0;
                    end
                end

                ST_WAKE: begin
                    idle_count <= '0;
                    if (global_power_down) begin
                        state          <= ST_SLEEP;
                        mem_power_down <= 1'b1;
                    end else begin
                        state <= ST_ACTIVE;
                    end
                end

                default: begin
                    state          <= ST_ACTIVE;
                    mem_power_down <= 1'b0;
                    idle_count     <= '0;
                end
            endcase
        end
    end

endmodule
